// File: rtl/gate_exerciser.sv
// Clocked stimulus/checker around a combinational gate: walks every input
// vector, waits a settle time, samples the output and scores it against a truth table.
module gate_exerciser #(
    parameter int                        N_INPUTS      = 1,
    parameter int                        SETTLE_CYCLES = 2,
    parameter logic [2**N_INPUTS-1:0]    TRUTH_TABLE   = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [N_INPUTS-1:0]   dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_INPUTS:0]     err_count,
    output logic [N_INPUTS-1:0]   fail_vec,
    output logic                  fail_valid
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [N_INPUTS-1:0] LAST_VEC = '1;
    localparam logic [CW-1:0]       RELOAD   = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state;
    logic [N_INPUTS-1:0] vec;
    logic [CW-1:0]       cnt;
    logic                mismatch;
    logic [N_INPUTS:0]   err_next;

    // Case inequality so X/Z on the gate output scores as a failure.
    always_comb begin
        mismatch = (dut_out !== TRUTH_TABLE[vec]);
        err_next = err_count + (N_INPUTS + 1)'(mismatch);
    end

    assign dut_in = vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        cnt        <= RELOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!fail_valid) begin
                            fail_vec   <= vec;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        cnt   <= RELOAD;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_exerciser.sv
// Directed + randomized bench for gate_exerciser: a 1-input default instance and
// a 2-input NAND instance, scored against a vector-walk reference model.
module tb_gate_exerciser;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] gt_a = '0, gt_b = '0;
    logic        z_a = 1'b0, z_b = 1'b0;
    logic [0:0]  dut_in_a;
    logic [1:0]  dut_in_b;
    logic        busy_a, done_a, pass_a, fval_a, busy_b, done_b, pass_b, fval_b;
    logic [1:0]  err_a;
    logic [2:0]  err_b;
    logic [0:0]  fv_a;
    logic [1:0]  fv_b;
    wire         dout_a = z_a ? 1'bz : gt_a[dut_in_a];
    wire         dout_b = z_b ? 1'bz : gt_b[dut_in_b];

    gate_exerciser u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_vec(fv_a), .fail_valid(fval_a));

    gate_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(1), .TRUTH_TABLE(4'b0111)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_vec(fv_b), .fail_valid(fval_b));

    int errors = 0;
    int checks = 0;
    int o_in, o_err, o_fv;
    logic o_busy, o_done, o_pass, o_fval;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int which);
        if (which == 0) begin
            o_in = int'(dut_in_a); o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            o_err = int'(err_a); o_fv = int'(fv_a); o_fval = fval_a;
        end else begin
            o_in = int'(dut_in_b); o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            o_err = int'(err_b); o_fv = int'(fv_b); o_fval = fval_b;
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v; else start_b = v;
    endtask

    // One full run. Expected results come from walking every vector k and
    // comparing the gate's response to the table bit k.
    task automatic run(input int which, input logic [15:0] tbl, input logic zmode,
                       input logic repulse, input string tag);
        int nv, s, len, exp_err, exp_fv;
        logic exp_fval, gv;
        logic [15:0] tt;
        nv = (which == 0) ? 2 : 4;
        s  = (which == 0) ? 2 : 1;
        tt = (which == 0) ? 16'b01 : 16'b0111;
        len = nv * (s + 1);
        exp_err = 0; exp_fv = 0; exp_fval = 1'b0;
        for (int k = 0; k < nv; k++) begin
            gv = zmode ? 1'bz : tbl[k];
            if (gv !== tt[k]) begin
                if (!exp_fval) exp_fv = k;
                exp_fval = 1'b1;
                exp_err++;
            end
        end
        if (which == 0) begin gt_a = tbl; z_a = zmode; end
        else            begin gt_b = tbl; z_b = zmode; end
        @(negedge clk);
        set_start(which, 1'b1);
        for (int j = 0; j <= len; j++) begin
            @(posedge clk); #1;
            if (j == 0 || (repulse && j == 3)) set_start(which, 1'b0);
            if (repulse && j == 2) set_start(which, 1'b1);
            sample(which);
            chk({tag, ".dut_in"}, o_in, (j < len) ? j / (s + 1) : nv - 1);
            chk({tag, ".busy"}, int'(o_busy), int'(j < len));
            chk({tag, ".done"}, int'(o_done), int'(j == len));
        end
        chk({tag, ".err_count"}, o_err, exp_err);
        chk({tag, ".fail_valid"}, int'(o_fval), int'(exp_fval));
        chk({tag, ".fail_vec"}, o_fv, exp_fv);
        chk({tag, ".pass"}, int'(o_pass), int'(exp_err == 0));
        // DONE must hold when start stays low.
        @(posedge clk); #1;
        sample(which);
        chk({tag, ".done_hold"}, int'(o_done), 1);
        chk({tag, ".err_hold"}, o_err, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        sample(0);
        chk("reset.a_in", o_in, 0);
        chk("reset.a_busy", int'(o_busy), 0);
        chk("reset.a_done", int'(o_done), 0);
        chk("reset.a_pass", int'(o_pass), 0);
        chk("reset.a_err", o_err, 0);
        chk("reset.a_fval", int'(o_fval), 0);
        sample(1);
        chk("reset.b_busy", int'(o_busy), 0);
        chk("reset.b_err", o_err, 0);
        @(negedge clk); rst = 1'b0;

        run(0, 16'b01, 1'b0, 1'b0, "inverter");
        run(0, 16'b10, 1'b0, 1'b0, "buffer");
        run(0, 16'b00, 1'b1, 1'b0, "hiz");
        run(1, 16'b0111, 1'b0, 1'b0, "nand");
        run(1, 16'b1000, 1'b0, 1'b0, "and");
        run(0, 16'b01, 1'b0, 1'b1, "repulse");

        // Async reset while vector 1 is settling: takes effect before the next edge.
        z_a = 1'b0; gt_a = 16'b10;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        sample(0);
        chk("midrun.in_before", o_in, 1);
        rst = 1'b1; #1;
        sample(0);
        chk("midrun.in", o_in, 0);
        chk("midrun.busy", int'(o_busy), 0);
        chk("midrun.err", o_err, 0);
        chk("midrun.fval", int'(o_fval), 0);
        @(negedge clk); rst = 1'b0;
        run(0, 16'b01, 1'b0, 1'b0, "after_rst");

        // Start held high: DONE lasts one cycle, next run restarts from vector 0.
        gt_a = 16'b10; z_a = 1'b0;
        @(negedge clk); start_a = 1'b1;
        for (int j = 0; j <= 13; j++) begin
            @(posedge clk); #1;
            sample(0);
            chk("b2b.done", int'(o_done), int'(j == 6 || j == 13));
            if (j == 6) chk("b2b.err_done", o_err, 2);
            if (j == 7) begin
                chk("b2b.err_clr", o_err, 0);
                chk("b2b.busy", int'(o_busy), 1);
                chk("b2b.in", o_in, 0);
            end
        end
        start_a = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            run(0, 16'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), "rand_a");
            run(1, 16'($urandom_range(0, 15)), 1'b0, 1'b0, "rand_b");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Clocked stimulus/checker stage that sits directly upstream and downstream of a combinational gate under test, such as the switch-level inverter.
- Drives every input vector of the gate in ascending order and waits a programmable settle time.
- Samples the gate output and compares it against a parameterised truth table.
- Reports pass/fail, the error count and the first failing vector; the lab benches use it so gate checks are self-checking instead of relying on $display inspection.

Parameters:
- N_INPUTS, 1, number of gate inputs; legal range 1..4.
- SETTLE_CYCLES, 2, clock cycles dut_in is held stable before sampling; must be >= 1.
- TRUTH_TABLE, 2'b01, expected output per vector (width 2**N_INPUTS); bit k = expected dut_out when dut_in == k. Default = inverter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  run request; sampled in IDLE or DONE only.
- dut_in  output  N_INPUTS  stimulus to gate inputs (bit 0 = gate input a).
- dut_out  input  1  gate output under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until next start or reset.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  N_INPUTS+1  mismatching vectors in the last run; cannot overflow.
- fail_vec  output  N_INPUTS  first mismatching vector; valid when fail_valid = 1.
- fail_valid  output  1  at least one mismatch captured this run.

Behaviour:
- rst high (async, regardless of clk): state = IDLE, dut_in = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 0, fail_valid = 0. Takes effect immediately, including mid-run; no partial results survive.
- States: IDLE, SETTLE, SAMPLE, DONE. Registers: vec (N_INPUTS bits), settle counter.
- IDLE / DONE with start = 1:
  - Next edge: dut_in = 0, vec = 0, err_count = 0, fail_valid = 0, fail_vec = 0, done = 0, pass = 0, busy = 1.
  - Settle counter loads SETTLE_CYCLES; state goes to SETTLE.
- IDLE / DONE with start = 0: hold all outputs.
- SETTLE: decrement counter each cycle; dut_in stable. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (exactly 1 cycle): mismatch = (dut_out !== TRUTH_TABLE[vec]), so X or Z on dut_out counts as a mismatch.
  - On mismatch: err_count += 1; if fail_valid == 0, fail_vec = vec and fail_valid = 1.
  - If vec == 2**N_INPUTS - 1: go to DONE; busy = 0, done = 1, pass = (final err_count == 0).
  - Otherwise: vec += 1, dut_in = vec + 1, counter reloads SETTLE_CYCLES, go to SETTLE.
- dut_in always equals vec; it changes only on the edge leaving IDLE/DONE or SAMPLE.
- Latency: done rises 2**N_INPUTS * (SETTLE_CYCLES + 1) rising edges after the edge that accepted start. Default = 6 edges.
- start while busy: ignored, no restart, no effect on counters.
- start held high continuously: run repeats back-to-back. Each DONE lasts exactly 1 cycle with done = 1 visible, then a new run begins.
- err_count only updates in SAMPLE; it is stable and readable in DONE.
- No combinational path from dut_out to any output; all outputs are registered.

Test Plan:
- Default params, inverter model, pulse start 1 cycle -> dut_in 0 for 3 cycles then 1 for 3 cycles; done = 1 at edge 6; pass = 1, err_count = 0, fail_valid = 0.
- Default params, buffer (y = a) in place of inverter -> done at edge 6; pass = 0, err_count = 2, fail_valid = 1, fail_vec = 0.
- Default params, dut_out tied to 1'bz -> err_count = 2, pass = 0, fail_vec = 0 (Z counted as mismatch).
- N_INPUTS = 2, TRUTH_TABLE = 4'b0111 (NAND), SETTLE_CYCLES = 1, correct NAND -> dut_in sequence 0,1,2,3, two cycles each; done at edge 8; pass = 1. Same setup with an AND gate -> err_count = 4, fail_vec = 0.
- Default params, start re-pulsed at edge 2 of a run -> ignored; done still at edge 6 with single-run results.
- Assert rst during SETTLE of vector 1 (asynchronously, between edges) -> dut_in = 0, busy = 0, err_count = 0 immediately. A fresh start then completes normally with pass = 1.
